adc_window_average: RTL and testbench
=====================================

# adc_window_average

Parametrised windowed averager for one signed ADC stream in the SPGD metric path. It averages a run-time selectable power-of-two window of 2^LOG2_N valid samples and publishes a registered signed mean with a one-cycle DONE pulse. It supports one-shot and back-to-back continuous windows, and sits between the ADC capture logic and the SPGD gradient/update logic. Unlike the fixed-window averager it replaces, it counts only qualified samples (DATA_VALID), has a start/busy handshake, and sign-extends and scales exactly for any window length.

## Interface
- ADC_WIDTH, 12, sample and result width (signed two's complement)
- LOG2_MAX, 10, largest supported log2 window; accumulator width ACC_W = ADC_WIDTH + LOG2_MAX
- LOG2_W, 4, width of LOG2_N port; must satisfy 2^LOG2_W > LOG2_MAX
- CLK  in  1  clock; all logic on rising edge
- RST_N  in  1  synchronous active-low reset; one clock, one reset, fixed as stated
- START  in  1  begin (or restart) a window; level-sampled each cycle
- CONTINUOUS  in  1  1: start next window automatically at window end; sampled at each window end
- LOG2_N  in  LOG2_W  log2 of window length; latched on accepted START; values > LOG2_MAX clamp to LOG2_MAX
- DATA_VALID  in  1  DATA_IN qualifier
- DATA_IN  in  ADC_WIDTH  signed sample
- BUSY  out  1  high while a window is accumulating
- DONE  out  1  one-cycle pulse, DATA_OUT updated same cycle
- DATA_OUT  out  ADC_WIDTH  signed mean of last completed window; held between windows

## Operation
- States: IDLE, ACCUM. Reset -> IDLE, acc=0, cnt=0, BUSY=0, DONE=0, DATA_OUT=0.
- IDLE: START=1 -> latch clamped LOG2_N into n_reg, acc=0, cnt=0, go ACCUM. Sample present the START cycle is not counted.
- ACCUM, DATA_VALID=1: acc += sign_extend(DATA_IN) to ACC_W; cnt += 1.
- Window end = valid sample with cnt == 2^n_reg - 1:
  - result = (acc + sample) >>> n_reg (arithmetic), low ADC_WIDTH bits registered to DATA_OUT; DONE=1 next cycle.
  - acc=0, cnt=0.
  - CONTINUOUS=1: stay ACCUM, n_reg unchanged. CONTINUOUS=0: go IDLE.
- START=1 in ACCUM: abort; discard acc, relatch LOG2_N, clear cnt, stay ACCUM; that cycle's sample discarded; no DONE for aborted window. START on the window-end cycle: the window completes (DONE issued), then restart takes effect (acc/cnt cleared, LOG2_N relatched, ACCUM regardless of CONTINUOUS).
- n_reg=0: each valid sample is a full window; DATA_OUT = sample.
- Arithmetic: exact full-precision sum; the mean of in-range signed samples always fits ADC_WIDTH, so there is no saturation.
- DATA_VALID ignored in IDLE.

## Timing
- Latency: final valid sample at edge k -> DATA_OUT and DONE valid after edge k+1, DONE low after k+2.
- Continuous mode has no gap: a valid sample at cycle k+1 counts toward the next window.
- BUSY = 1 in ACCUM (registered); rises one cycle after accepted START; falls the cycle DONE rises (one-shot).
- RST_N low mid-window: next edge forces reset values; partial window lost; no DONE.
- Max throughput: one sample per clock; min DONE spacing 2^n_reg cycles.

## Configuration
- ADC_AVG_ROUND_EN defined: result = (sum + 2^(n_reg-1)) >>> n_reg for n_reg > 0 (round half toward +inf); n_reg=0 unchanged. Still cannot overflow, since the added term is < 2^n_reg.
- Undefined: pure arithmetic shift (floor). All other behaviour identical.

## Test plan
- Reset/idle: RST_N low 3 cycles with DATA_VALID toggling -> DATA_OUT=0, BUSY=0, DONE=0; no accumulation in IDLE.
- One-shot, LOG2_N=2, samples 100,101,102,103 with gaps in DATA_VALID -> DONE once, 1 cycle after 4th sample; DATA_OUT=101 (floor) or 102 (ROUND_EN); BUSY falls with DONE.
- Negatives, LOG2_N=1, samples -3,-2 -> DATA_OUT=-3 (floor) / -2 (ROUND_EN); LOG2_N=3 all -2048 -> -2048; all 2047 -> 2047 either build.
- Continuous, LOG2_N=3, DATA_VALID always 1, ramp 0..31 -> DONE every 8 cycles; DATA_OUT=3,11,19,27 (floor) / 4,12,20,28 (ROUND_EN); no dropped sample.
- Abort/clamp: START after 5 of 16 samples -> no DONE, window restarts from zero; LOG2_N=15 with LOG2_MAX=10 -> DONE after exactly 1024 valid samples.
- Reset mid-window and LOG2_N=0: RST_N low after 3 of 8 samples -> no DONE, outputs reset; then LOG2_N=0, CONTINUOUS=1, samples 7,-5 -> DATA_OUT 7 then -5 on consecutive DONEs.

Source files
------------

// File: rtl/adc_window_average.sv
// adc_window_average: power-of-two windowed mean of a signed ADC stream with start/busy/done handshake
// Ports:
//   CLK        rising-edge clock
//   RST_N      synchronous active-low reset
//   START      begin or restart a window (latches LOG2_N, clamped to LOG2_MAX)
//   CONTINUOUS when high at a window end, the next window starts with no gap
//   LOG2_N     log2 of the window length
//   DATA_VALID qualifies DATA_IN; only qualified samples are counted
//   DATA_IN    signed sample
//   BUSY       high while a window is accumulating
//   DONE       one-cycle pulse; DATA_OUT updates in the same cycle
//   DATA_OUT   signed mean of the last completed window, held between windows
// Build option: define ADC_AVG_ROUND_EN to round half toward +inf instead of flooring.
module adc_window_average #(
   parameter int ADC_WIDTH = 12,
   parameter int LOG2_MAX  = 10,
   parameter int LOG2_W    = 4
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        START,
   input  logic                        CONTINUOUS,
   input  logic [LOG2_W-1:0]           LOG2_N,
   input  logic                        DATA_VALID,
   input  logic signed [ADC_WIDTH-1:0] DATA_IN,
   output logic                        BUSY,
   output logic                        DONE,
   output logic signed [ADC_WIDTH-1:0] DATA_OUT
);
   localparam int ACC_W = ADC_WIDTH + LOG2_MAX;
   // one extra bit so 2^LOG2_MAX itself is representable in the end-of-window test
   localparam int CNT_W = LOG2_MAX + 1;
   typedef enum logic {IDLE, ACCUM} state_t;
   state_t                    state;
   logic [LOG2_W-1:0]         n_reg;
   logic [LOG2_W-1:0]         n_clamp;
   logic [CNT_W-1:0]          cnt;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   sum;
   logic signed [ACC_W-1:0]   total;
   logic                      last;
   always_comb begin
      n_clamp = LOG2_N > LOG2_W'(LOG2_MAX) ? LOG2_W'(LOG2_MAX) : LOG2_N;
      sum     = acc + {{LOG2_MAX{DATA_IN[ADC_WIDTH-1]}}, DATA_IN};
      last    = (cnt + CNT_W'(1)) == (CNT_W'(1) << n_reg);
`ifdef ADC_AVG_ROUND_EN
      // the added half-LSB is below 2^n_reg, so the full-precision sum cannot overflow
      total   = n_reg == '0 ? sum : sum + (ACC_W'(1) << (n_reg - LOG2_W'(1)));
`else
      total   = sum;
`endif
   end
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= IDLE;
         n_reg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         DATA_OUT <= '0;
      end else begin
         DONE <= 1'b0;
         if (state == ACCUM && DATA_VALID) begin
            if (last) begin
               DONE     <= 1'b1;
               DATA_OUT <= ADC_WIDTH'(total >>> n_reg);
               acc      <= '0;
               cnt      <= '0;
               if (!CONTINUOUS) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            end else begin
               acc <= sum;
               cnt <= cnt + CNT_W'(1);
            end
         end
         // START wins over any accumulation above; a completing window still publishes first
         if (START) begin
            n_reg <= n_clamp;
            acc   <= '0;
            cnt   <= '0;
            state <= ACCUM;
            BUSY  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_adc_window_average.sv
// tb_adc_window_average: randomized and directed check of adc_window_average against a queue-based window model
module tb_adc_window_average;
   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               s_start = 1'b0;
   logic               s_cont = 1'b0;
   logic [3:0]         s_l2n = '0;
   logic               s_dv = 1'b0;
   logic signed [11:0] s_din = '0;
   logic               busy;
   logic               done;
   logic signed [11:0] dout;
   int n_vec = 0;
   int n_err = 0;
   logic chk_en = 1'b0;
   logic               exp_busy = 1'b0;
   logic               exp_done = 1'b0;
   logic signed [11:0] exp_out = '0;
   bit  active = 1'b0;
   int  n_win = 0;
   int  q[$];
   int  done_q[$];
   adc_window_average dut (
      .CLK(clk), .RST_N(rst_n), .START(s_start), .CONTINUOUS(s_cont), .LOG2_N(s_l2n),
      .DATA_VALID(s_dv), .DATA_IN(s_din), .BUSY(busy), .DONE(done), .DATA_OUT(dout)
   );
   always #5 clk = ~clk;
   task automatic chk(string nm, int got, int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
      end
   endtask
   // model: a window is the list of qualified samples since its start; it ends when it holds 2^n of them
   task automatic tick();
      longint s;
      if (!rst_n) begin
         active = 1'b0;
         q.delete();
         exp_busy = 1'b0;
         exp_done = 1'b0;
         exp_out = '0;
      end else begin
         exp_done = 1'b0;
         if (active && s_dv) begin
            q.push_back(int'(s_din));
            if (q.size() == (1 << n_win)) begin
               s = 0;
               foreach (q[i]) s += q[i];
`ifdef ADC_AVG_ROUND_EN
               if (n_win > 0) s += longint'(1) << (n_win - 1);
`endif
               s = s >>> n_win;
               exp_out = s[11:0];
               exp_done = 1'b1;
               q.delete();
               if (!s_cont) active = 1'b0;
            end
         end
         if (s_start) begin
            active = 1'b1;
            n_win = s_l2n > 10 ? 10 : int'(s_l2n);
            q.delete();
         end
         exp_busy = active;
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic drive(bit st, bit ct, int l2, bit v, int d);
      s_start = st;
      s_cont = ct;
      s_l2n = 4'(l2);
      s_dv = v;
      s_din = 12'(d);
      tick();
   endtask
   task automatic idle(int k);
      for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0);
   endtask
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("busy", int'(busy), int'(exp_busy));
         chk("done", int'(done), int'(exp_done));
         chk("data_out", int'(dout), int'(exp_out));
         if (done) done_q.push_back(int'(dout));
      end
   end
   initial begin
      chk_en = 1'b1;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) drive(0, 0, 2, i[0], int'($urandom));
      chk("rst_out", int'(dout), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) drive(0, 0, 2, 1, int'($urandom));
      chk("idle_no_done", done_q.size(), 0);
      done_q.delete();
      drive(1, 0, 2, 1, 55);
      drive(0, 0, 2, 1, 100);
      drive(0, 0, 2, 0, 0);
      drive(0, 0, 2, 1, 101);
      idle(2);
      drive(0, 0, 2, 1, 102);
      drive(0, 0, 2, 1, 103);
      idle(3);
      chk("oneshot_count", done_q.size(), 1);
`ifdef ADC_AVG_ROUND_EN
      chk("oneshot_val", done_q.size() > 0 ? done_q[0] : -9999, 102);
`else
      chk("oneshot_val", done_q.size() > 0 ? done_q[0] : -9999, 101);
`endif
      chk("oneshot_busy", int'(busy), 0);
      done_q.delete();
      drive(1, 0, 1, 0, 0);
      drive(0, 0, 0, 1, -3);
      drive(0, 0, 0, 1, -2);
      idle(2);
`ifdef ADC_AVG_ROUND_EN
      chk("neg_val", done_q.size() > 0 ? done_q[0] : -9999, -2);
`else
      chk("neg_val", done_q.size() > 0 ? done_q[0] : -9999, -3);
`endif
      done_q.delete();
      drive(1, 0, 3, 0, 0);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, -2048);
      idle(2);
      drive(1, 0, 3, 0, 0);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 2047);
      idle(2);
      chk("min_val", done_q.size() > 0 ? done_q[0] : -9999, -2048);
      chk("max_val", done_q.size() > 1 ? done_q[1] : -9999, 2047);
      done_q.delete();
      drive(1, 1, 3, 0, 0);
      for (int i = 0; i < 32; i++) drive(0, i != 31, 0, 1, i);
      idle(3);
      chk("cont_count", done_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
`ifdef ADC_AVG_ROUND_EN
         chk("cont_val", done_q.size() > k ? done_q[k] : -9999, 4 + 8 * k);
`else
         chk("cont_val", done_q.size() > k ? done_q[k] : -9999, 3 + 8 * k);
`endif
      end
      done_q.delete();
      drive(1, 0, 4, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, int'($urandom));
      drive(1, 0, 4, 1, int'($urandom));
      for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, int'($urandom));
      idle(2);
      chk("abort_count", done_q.size(), 1);
      done_q.delete();
      drive(1, 0, 15, 0, 0);
      for (int i = 0; i < 1024; i++) begin
         drive(0, 0, 0, 1, 5);
         if (i == 1022) chk("clamp_early", done_q.size(), 0);
      end
      chk("clamp_count", done_q.size(), 1);
      chk("clamp_val", done_q.size() > 0 ? done_q[0] : -9999, 5);
      idle(2);
      done_q.delete();
      drive(1, 0, 3, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 40);
      rst_n = 1'b0;
      drive(0, 0, 0, 1, 9);
      rst_n = 1'b1;
      idle(9);
      chk("midrst_done", done_q.size(), 0);
      chk("midrst_out", int'(dout), 0);
      chk("midrst_busy", int'(busy), 0);
      drive(1, 1, 0, 1, 99);
      drive(0, 1, 0, 1, 7);
      drive(0, 0, 0, 1, -5);
      idle(2);
      chk("n0_count", done_q.size(), 2);
      chk("n0_first", done_q.size() > 0 ? done_q[0] : -9999, 7);
      chk("n0_second", done_q.size() > 1 ? done_q[1] : -9999, -5);
      for (int i = 0; i < 3000; i++) begin
         rst_n = $urandom_range(0, 199) != 0;
         drive($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)),
               $urandom_range(0, 3) != 0, int'($urandom));
      end
      rst_n = 1'b1;
      idle(2);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
